bram_block_dp: RTL and testbench
================================

# bram_block_dp

Parametrised true dual-port block RAM with per-byte write enables, selectable read-during-write behaviour, cross-port collision detection and an optional second output register. Successor to the single-port 4096x32 block; serves as a processor-side and DMA-side shared memory on the PLB/AXI bridges in the LX9 microboard designs. Both ports share one clock and map to Spartan-6 RAMB16 primitives when synthesised.

## Interface
Parameters:
- DATA_WIDTH, 32: word width in bits; multiple of 8; NB = DATA_WIDTH/8 byte lanes.
- DEPTH, 4096: words; power of two; AW = log2(DEPTH).
- ADDR_WIDTH, 32: width of byte-address inputs; must be ≥ AW + log2(NB).
- RDW_MODE, 0: same-port read-during-write: 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.

Ports (one clock; reset is synchronous and active-high):
- CLK  input  1  clock for both ports.
- RST  input  1  synchronous active-high reset of output/status registers.
- A_ADDR  input  ADDR_WIDTH  port A byte address; word index = A_ADDR[log2(NB) +: AW].
- A_EN  input  1  port A enable.
- A_WE  input  NB  port A byte write enables; all-zero = read.
- A_DI  input  DATA_WIDTH  port A write data.
- A_DO  output  DATA_WIDTH  port A read data.
- A_VLD  output  1  one-cycle strobe: A_DO updated this cycle.
- B_ADDR, B_EN, B_WE, B_DI, B_DO, B_VLD: identical for port B.
- COLLISION  output  1  one-cycle strobe: same-word access conflict detected.

## Operation
- Access on port p in cycle N when p_EN=1. p_WE=0 → read; p_WE≠0 → write of lanes with p_WE[i]=1 only; other lanes unchanged.
- p_EN=0: no access, p_DO holds, p_VLD=0.
- Same-port write, by RDW_MODE: READ_FIRST → p_DO = word before write, p_VLD=1; WRITE_FIRST → p_DO = merged word after write, p_VLD=1; NO_CHANGE → p_DO holds, p_VLD=0.
- Cross-port conflict = both enabled, same word index, at least one writing. COLLISION=1 one cycle after (aligned with the first-stage output).
- Write/write conflict: per byte lane, port A wins where both A_WE[i] and B_WE[i] are set; lanes written by only one port take that port's data.
- Read/write conflict: reading port returns word before the write (cross-port always READ_FIRST, independent of RDW_MODE).
- Address bits above and below the word index ignored; index wraps modulo DEPTH.
- Memory contents are not reset; power-up contents zero (initialised at configuration).

## Timing
- Base read latency 1: access in cycle N → p_DO valid, p_VLD=1 in cycle N+1.
- With BRAM_OUT_REG_EN: latency 2; p_VLD and COLLISION delayed one cycle to match.
- Back-to-back accesses every cycle on both ports, no stalls; no handshake beyond EN.
- Reset values: A_DO=B_DO=0, A_VLD=B_VLD=0, COLLISION=0, all pipeline stages cleared.
- RST has priority: accesses presented in a cycle with RST=1 are discarded (no write, no strobe). Accesses already in flight when RST rises are flushed; their strobes never appear.
- RST never alters memory contents.

## Configuration
- BRAM_OUT_REG_EN defined: extra output register per port (maps to RAMB16 DOREG), latency 2, p_DO changes only with p_VLD.
- Undefined: single register stage, latency 1.

## Test plan
- Port A write 0xDEADBEEF WE=0xF to byte addr 0x10, then read addr 0x10 on B → B_DO=0xDEADBEEF, B_VLD=1 exactly 1 cycle (2 with macro) after read.
- Word 0=0x11223344; A writes WE=0x2 DI=0xAABBCCDD → readback 0x1122CC44.
- RDW_MODE 0/1/2, word 0x00000000, A writes 0xFFFFFFFF WE=0xF → A_DO=0x00000000 VLD=1 / 0xFFFFFFFF VLD=1 / unchanged VLD=0.
- Same cycle: A writes 0x11111111 WE=0x3, B writes 0x22222222 WE=0x6 to same word (was 0) → word=0x00221111, COLLISION=1 one cycle.
- A writes 0x5A5A5A5A while B reads same word (was 0x01020304) → B_DO=0x01020304, COLLISION=1; next B read → 0x5A5A5A5A.
- Read issued, RST asserted next cycle → no VLD strobe, A_DO=0; write issued with RST=1 → memory unchanged on readback.

Source files
------------

// File: rtl/bram_block_dp.sv
// True dual-port byte-write RAM, shared clock, cross-port collision strobe; optional output register via BRAM_OUT_REG_EN.
// Latency: 1 cycle from EN to DO/VLD (2 with BRAM_OUT_REG_EN); COLLISION aligned with VLD.
// Backpressure: none, both ports accept an access every cycle; EN is the only qualifier.
module bram_block_dp #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = 32,
    parameter int RDW_MODE   = 0
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [ADDR_WIDTH-1:0]     A_ADDR,
    input  logic                      A_EN,
    input  logic [DATA_WIDTH/8-1:0]   A_WE,
    input  logic [DATA_WIDTH-1:0]     A_DI,
    output logic [DATA_WIDTH-1:0]     A_DO,
    output logic                      A_VLD,
    input  logic [ADDR_WIDTH-1:0]     B_ADDR,
    input  logic                      B_EN,
    input  logic [DATA_WIDTH/8-1:0]   B_WE,
    input  logic [DATA_WIDTH-1:0]     B_DI,
    output logic [DATA_WIDTH-1:0]     B_DO,
    output logic                      B_VLD,
    output logic                      COLLISION
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(NB);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]         a_idx, b_idx;
    logic                  a_wr, b_wr;
    logic [DATA_WIDTH-1:0] a_old, b_old;
    logic                  unused_addr_bits;

    assign a_idx = A_ADDR[BW +: AW];
    assign b_idx = B_ADDR[BW +: AW];
    assign a_wr  = A_EN && (|A_WE);
    assign b_wr  = B_EN && (|B_WE);
    assign a_old = mem_q[a_idx];
    assign b_old = mem_q[b_idx];
    assign unused_addr_bits = ^{A_ADDR, B_ADDR};

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_w,
                                                    input logic [DATA_WIDTH-1:0] di,
                                                    input logic [NB-1:0]         we);
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++) begin
            if (we[i]) r[8*i +: 8] = di[8*i +: 8];
        end
        return r;
    endfunction

    // Port A's update is issued last so it wins lanes that both ports write.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < NB; i++) begin
                if (B_EN && B_WE[i]) mem_q[b_idx][8*i +: 8] <= B_DI[8*i +: 8];
                if (A_EN && A_WE[i]) mem_q[a_idx][8*i +: 8] <= A_DI[8*i +: 8];
            end
        end
    end

    logic                  a_vld_d, a_vld_q, b_vld_d, b_vld_q, col_d, col_q;
    logic [DATA_WIDTH-1:0] a_do_d, a_do_q, b_do_d, b_do_q;

    // Cross-port reads see the pre-write word because only the own port's data is merged.
    always_comb begin
        a_vld_d = A_EN && !(a_wr && RDW_MODE == 2);
        b_vld_d = B_EN && !(b_wr && RDW_MODE == 2);
        a_do_d  = a_do_q;
        b_do_d  = b_do_q;
        if (a_vld_d) a_do_d = (a_wr && RDW_MODE == 1) ? merge(a_old, A_DI, A_WE) : a_old;
        if (b_vld_d) b_do_d = (b_wr && RDW_MODE == 1) ? merge(b_old, B_DI, B_WE) : b_old;
        col_d = A_EN && B_EN && (a_idx == b_idx) && (a_wr || b_wr);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_vld_q <= 1'b0;
            b_vld_q <= 1'b0;
            col_q   <= 1'b0;
            a_do_q  <= '0;
            b_do_q  <= '0;
        end else begin
            a_vld_q <= a_vld_d;
            b_vld_q <= b_vld_d;
            col_q   <= col_d;
            a_do_q  <= a_do_d;
            b_do_q  <= b_do_d;
        end
    end

`ifdef BRAM_OUT_REG_EN
    logic                  a_vld2_q, b_vld2_q, col2_q;
    logic [DATA_WIDTH-1:0] a_do2_q, b_do2_q;

    // Second stage only loads on a strobe so DO moves exactly with VLD.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_vld2_q <= 1'b0;
            b_vld2_q <= 1'b0;
            col2_q   <= 1'b0;
            a_do2_q  <= '0;
            b_do2_q  <= '0;
        end else begin
            a_vld2_q <= a_vld_q;
            b_vld2_q <= b_vld_q;
            col2_q   <= col_q;
            if (a_vld_q) a_do2_q <= a_do_q;
            if (b_vld_q) b_do2_q <= b_do_q;
        end
    end

    assign A_DO      = a_do2_q;
    assign A_VLD     = a_vld2_q;
    assign B_DO      = b_do2_q;
    assign B_VLD     = b_vld2_q;
    assign COLLISION = col2_q;
`else
    assign A_DO      = a_do_q;
    assign A_VLD     = a_vld_q;
    assign B_DO      = b_do_q;
    assign B_VLD     = b_vld_q;
    assign COLLISION = col_q;
`endif
endmodule

// File: tb/tb_bram_block_dp.sv
// Directed bench for bram_block_dp: vector table on a READ_FIRST instance plus
// hand sequences for read-during-write modes and reset behaviour.
module tb_bram_block_dp;
`ifdef BRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic        a_en;
        logic [3:0]  a_we;
        logic [31:0] a_addr;
        logic [31:0] a_di;
        logic        b_en;
        logic [3:0]  b_we;
        logic [31:0] b_addr;
        logic [31:0] b_di;
        logic        e_avld;
        logic [31:0] e_ado;
        logic        e_bvld;
        logic [31:0] e_bdo;
        logic        e_col;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] A_ADDR, B_ADDR, A_DI, B_DI;
    logic        A_EN, B_EN;
    logic [3:0]  A_WE, B_WE;
    logic [31:0] A_DO, B_DO, A_DO1, B_DO1, A_DO2, B_DO2;
    logic        A_VLD, B_VLD, COLLISION;
    logic        A_VLD1, B_VLD1, COL1, A_VLD2, B_VLD2, COL2;

    int tests = 0;
    int fails = 0;
    vec_t tbl[$];
    vec_t idle_v;

    always #5 CLK = ~CLK;

    bram_block_dp #(.RDW_MODE(0)) dut0 (
        .CLK(CLK), .RST(RST),
        .A_ADDR(A_ADDR), .A_EN(A_EN), .A_WE(A_WE), .A_DI(A_DI), .A_DO(A_DO), .A_VLD(A_VLD),
        .B_ADDR(B_ADDR), .B_EN(B_EN), .B_WE(B_WE), .B_DI(B_DI), .B_DO(B_DO), .B_VLD(B_VLD),
        .COLLISION(COLLISION)
    );
    bram_block_dp #(.RDW_MODE(1)) dut1 (
        .CLK(CLK), .RST(RST),
        .A_ADDR(A_ADDR), .A_EN(A_EN), .A_WE(A_WE), .A_DI(A_DI), .A_DO(A_DO1), .A_VLD(A_VLD1),
        .B_ADDR(B_ADDR), .B_EN(B_EN), .B_WE(B_WE), .B_DI(B_DI), .B_DO(B_DO1), .B_VLD(B_VLD1),
        .COLLISION(COL1)
    );
    bram_block_dp #(.RDW_MODE(2)) dut2 (
        .CLK(CLK), .RST(RST),
        .A_ADDR(A_ADDR), .A_EN(A_EN), .A_WE(A_WE), .A_DI(A_DI), .A_DO(A_DO2), .A_VLD(A_VLD2),
        .B_ADDR(B_ADDR), .B_EN(B_EN), .B_WE(B_WE), .B_DI(B_DI), .B_DO(B_DO2), .B_VLD(B_VLD2),
        .COLLISION(COL2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        A_EN = v.a_en; A_WE = v.a_we; A_ADDR = v.a_addr; A_DI = v.a_di;
        B_EN = v.b_en; B_WE = v.b_we; B_ADDR = v.b_addr; B_DI = v.b_di;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t rd_a(input logic [31:0] addr);
        vec_t v;
        v = idle_v;
        v.a_en = 1'b1; v.a_addr = addr;
        return v;
    endfunction

    initial begin
        idle_v = '{1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        //           a_en a_we a_addr       a_di          b_en b_we b_addr       b_di          avld ado           bvld bdo           col
        tbl.push_back('{1'b1, 4'hF, 32'h10,        32'hDEADBEEF, 1'b0, 4'h0, 32'h0,         32'h0,        1'b1, 32'h00000000, 1'b0, 32'h00000000, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 32'h0,         32'h0,        1'b1, 4'h0, 32'h10,        32'h0,        1'b0, 32'h00000000, 1'b1, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 32'h0,         32'h0,        1'b0, 4'h0, 32'h0,         32'h0,        1'b0, 32'h00000000, 1'b0, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b1, 4'hF, 32'h0,         32'h11223344, 1'b0, 4'h0, 32'h0,         32'h0,        1'b1, 32'h00000000, 1'b0, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b1, 4'h2, 32'h0,         32'hAABBCCDD, 1'b0, 4'h0, 32'h0,         32'h0,        1'b1, 32'h11223344, 1'b0, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 32'h0,         32'h0,        1'b0, 4'h0, 32'h0,         32'h0,        1'b1, 32'h1122CC44, 1'b0, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b1, 4'h3, 32'h20,        32'h11111111, 1'b1, 4'h6, 32'h20,        32'h22222222, 1'b1, 32'h00000000, 1'b1, 32'h00000000, 1'b1});
        tbl.push_back('{1'b1, 4'h0, 32'h20,        32'h0,        1'b0, 4'h0, 32'h0,         32'h0,        1'b1, 32'h00221111, 1'b0, 32'h00000000, 1'b0});
        tbl.push_back('{1'b1, 4'hF, 32'h30,        32'h01020304, 1'b0, 4'h0, 32'h0,         32'h0,        1'b1, 32'h00000000, 1'b0, 32'h00000000, 1'b0});
        tbl.push_back('{1'b1, 4'hF, 32'h30,        32'h5A5A5A5A, 1'b1, 4'h0, 32'h30,        32'h0,        1'b1, 32'h01020304, 1'b1, 32'h01020304, 1'b1});
        tbl.push_back('{1'b0, 4'h0, 32'h0,         32'h0,        1'b1, 4'h0, 32'h30,        32'h0,        1'b0, 32'h01020304, 1'b1, 32'h5A5A5A5A, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 32'h00004013,  32'h0,        1'b1, 4'h0, 32'hFFFFC012,  32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 32'h31,        32'h0,        1'b1, 4'hF, 32'h33,        32'hCAFEF00D, 1'b1, 32'h5A5A5A5A, 1'b1, 32'h5A5A5A5A, 1'b1});
        tbl.push_back('{1'b1, 4'h0, 32'h30,        32'h0,        1'b0, 4'h0, 32'h0,         32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 32'h5A5A5A5A, 1'b0});
        tbl.push_back('{1'b1, 4'hF, 32'h40,        32'h13572468, 1'b1, 4'hF, 32'h44,        32'h9ABCDEF0, 1'b1, 32'h00000000, 1'b1, 32'h00000000, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 32'h44,        32'h0,        1'b1, 4'h0, 32'h40,        32'h0,        1'b1, 32'h9ABCDEF0, 1'b1, 32'h13572468, 1'b0});

        RST = 1'b1;
        apply(idle_v);
        step();
        step();
        chk("reset A_DO", A_DO, 32'h0);
        chk("reset B_DO", B_DO, 32'h0);
        chk("reset A_VLD", {31'h0, A_VLD}, 32'h0);
        chk("reset B_VLD", {31'h0, B_VLD}, 32'h0);
        chk("reset COLLISION", {31'h0, COLLISION}, 32'h0);
        RST = 1'b0;

        for (int c = 0; c < tbl.size() + LAT - 1; c++) begin
            if (c < tbl.size()) apply(tbl[c]);
            else apply(idle_v);
            step();
            if (c - (LAT - 1) >= 0) begin
                int j;
                j = c - (LAT - 1);
                chk($sformatf("row%0d A_VLD", j), {31'h0, A_VLD}, {31'h0, tbl[j].e_avld});
                chk($sformatf("row%0d A_DO", j), A_DO, tbl[j].e_ado);
                chk($sformatf("row%0d B_VLD", j), {31'h0, B_VLD}, {31'h0, tbl[j].e_bvld});
                chk($sformatf("row%0d B_DO", j), B_DO, tbl[j].e_bdo);
                chk($sformatf("row%0d COLLISION", j), {31'h0, COLLISION}, {31'h0, tbl[j].e_col});
            end
        end

        // Read-during-write on the same port, all three modes side by side.
        apply(rd_a(32'h10));
        step();
        begin
            vec_t w;
            w = idle_v;
            w.a_en = 1'b1; w.a_we = 4'hF; w.a_addr = 32'h80; w.a_di = 32'hFFFFFFFF;
            apply(w);
        end
        step();
        apply(idle_v);
        if (LAT == 2) step();
        chk("rdw READ_FIRST A_DO", A_DO, 32'h00000000);
        chk("rdw READ_FIRST A_VLD", {31'h0, A_VLD}, 32'h1);
        chk("rdw WRITE_FIRST A_DO", A_DO1, 32'hFFFFFFFF);
        chk("rdw WRITE_FIRST A_VLD", {31'h0, A_VLD1}, 32'h1);
        chk("rdw NO_CHANGE A_DO", A_DO2, 32'hDEADBEEF);
        chk("rdw NO_CHANGE A_VLD", {31'h0, A_VLD2}, 32'h0);
        apply(rd_a(32'h80));
        step();
        apply(idle_v);
        if (LAT == 2) step();
        chk("rdw readback A_DO", A_DO, 32'hFFFFFFFF);
        chk("rdw readback NO_CHANGE A_DO", A_DO2, 32'hFFFFFFFF);

        // Reset flushes an in-flight read.
        apply(rd_a(32'h10));
        step();
        apply(idle_v);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("flush A_VLD", {31'h0, A_VLD}, 32'h0);
        chk("flush A_DO", A_DO, 32'h0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("flush late A_VLD %0d", k), {31'h0, A_VLD}, 32'h0);
        end

        // A write presented under reset must not land.
        begin
            vec_t w;
            w = idle_v;
            w.a_en = 1'b1; w.a_we = 4'hF; w.a_addr = 32'h10; w.a_di = 32'hBAD0BAD0;
            apply(w);
        end
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rst write A_VLD", {31'h0, A_VLD}, 32'h0);
        apply(rd_a(32'h10));
        step();
        apply(idle_v);
        if (LAT == 2) step();
        chk("rst write readback A_DO", A_DO, 32'hDEADBEEF);
        chk("rst write readback A_VLD", {31'h0, A_VLD}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
